// File: rtl/kim_id_ex_reg_p_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Holds the ALU opcode encodings, the funct width and the packed control bundle.
package kim_id_ex_reg_p_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam int         FUNCT_WIDTH  = 6;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // A bubble keeps the harmless fields but kills every side effect and forces an add.
  function automatic ctrl_t bubble_ctrl(input ctrl_t c);
    ctrl_t b;
    b           = c;
    b.alu_op    = ALU_OP_ADD;
    b.branch    = 1'b0;
    b.mem_read  = 1'b0;
    b.mem_write = 1'b0;
    b.reg_write = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/kim_load_use_detect_p.sv
// Combinational load-use hazard detector: a valid load in EX whose destination
// (rt, non-zero) is a source of the valid instruction sitting in ID.
module kim_load_use_detect_p #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt_addr,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  output logic                      hazard
);

  logic w_addr_match;

  assign w_addr_match = (ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr);
  assign hazard = ex_valid && ex_mem_read && (ex_rt_addr != '0) && id_valid && w_addr_match;

endmodule

// File: rtl/kim_id_ex_reg_p.sv
// ID/EX pipeline register with load-use detection, stall hold, flush and bubble insertion.
// Optional bubble/hold performance counters are enabled by defining KIM_IDEX_PERF_EN.
module kim_id_ex_reg_p
  import kim_id_ex_reg_p_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      flush_in,
  input  logic                      id_valid_in,
  input  logic [1:0]                id_alu_op_in,
  input  logic                      id_alu_src_in,
  input  logic                      id_reg_dst_in,
  input  logic                      id_branch_in,
  input  logic                      id_mem_read_in,
  input  logic                      id_mem_write_in,
  input  logic                      id_reg_write_in,
  input  logic                      id_mem_to_reg_in,
  input  logic [DATA_WIDTH-1:0]     id_rs_data_in,
  input  logic [DATA_WIDTH-1:0]     id_rt_data_in,
  input  logic [DATA_WIDTH-1:0]     id_imm_in,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_in,
  output logic                      ex_valid_out,
  output logic [1:0]                ex_alu_op_out,
  output logic                      ex_alu_src_out,
  output logic                      ex_reg_dst_out,
  output logic                      ex_branch_out,
  output logic                      ex_mem_read_out,
  output logic                      ex_mem_write_out,
  output logic                      ex_reg_write_out,
  output logic                      ex_mem_to_reg_out,
  output logic [DATA_WIDTH-1:0]     ex_rs_data_out,
  output logic [DATA_WIDTH-1:0]     ex_rt_data_out,
  output logic [DATA_WIDTH-1:0]     ex_imm_out,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4_out,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs_addr_out,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt_addr_out,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_out,
  output logic [FUNCT_WIDTH-1:0]    ex_funct_out,
  output logic                      load_use_stall_out
`ifdef KIM_IDEX_PERF_EN
  ,
  output logic [31:0]               bubble_cnt_out,
  output logic [31:0]               hold_cnt_out
`endif
);

  ctrl_t                     r_ctrl;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_rs_data;
  logic [DATA_WIDTH-1:0]     r_rt_data;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [DATA_WIDTH-1:0]     r_pc_plus4;
  logic [REG_ADDR_WIDTH-1:0] r_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rt_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;

  ctrl_t w_id_ctrl;
  logic  w_hazard;
  logic  w_load;
  logic  w_bubble;

  assign w_id_ctrl = '{alu_op:     id_alu_op_in,
                       alu_src:    id_alu_src_in,
                       reg_dst:    id_reg_dst_in,
                       branch:     id_branch_in,
                       mem_read:   id_mem_read_in,
                       mem_write:  id_mem_write_in,
                       reg_write:  id_reg_write_in,
                       mem_to_reg: id_mem_to_reg_in};

  kim_load_use_detect_p #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use (
    .ex_valid   (r_valid),
    .ex_mem_read(r_ctrl.mem_read),
    .ex_rt_addr (r_rt_addr),
    .id_valid   (id_valid_in),
    .id_rs_addr (id_rs_addr_in),
    .id_rt_addr (id_rt_addr_in),
    .hazard     (w_hazard)
  );

  // Flush overrides stall; a hazard only becomes a bubble when the stage is free to load.
  assign w_load             = flush_in | ~stall_in;
  assign w_bubble           = flush_in | (~stall_in & w_hazard);
  assign load_use_stall_out = w_hazard & ~flush_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus4 <= '0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_rd_addr  <= '0;
    end else if (w_load) begin
      r_ctrl     <= w_bubble ? bubble_ctrl(w_id_ctrl) : w_id_ctrl;
      r_valid    <= w_bubble ? 1'b0 : id_valid_in;
      r_rs_data  <= id_rs_data_in;
      r_rt_data  <= id_rt_data_in;
      r_imm      <= id_imm_in;
      r_pc_plus4 <= id_pc_plus4_in;
      r_rs_addr  <= id_rs_addr_in;
      r_rt_addr  <= id_rt_addr_in;
      r_rd_addr  <= id_rd_addr_in;
    end
  end

  assign ex_valid_out      = r_valid;
  assign ex_alu_op_out     = r_ctrl.alu_op;
  assign ex_alu_src_out    = r_ctrl.alu_src;
  assign ex_reg_dst_out    = r_ctrl.reg_dst;
  assign ex_branch_out     = r_ctrl.branch;
  assign ex_mem_read_out   = r_ctrl.mem_read;
  assign ex_mem_write_out  = r_ctrl.mem_write;
  assign ex_reg_write_out  = r_ctrl.reg_write;
  assign ex_mem_to_reg_out = r_ctrl.mem_to_reg;
  assign ex_rs_data_out    = r_rs_data;
  assign ex_rt_data_out    = r_rt_data;
  assign ex_imm_out        = r_imm;
  assign ex_pc_plus4_out   = r_pc_plus4;
  assign ex_rs_addr_out    = r_rs_addr;
  assign ex_rt_addr_out    = r_rt_addr;
  assign ex_rd_addr_out    = r_rd_addr;
  assign ex_funct_out      = r_imm[FUNCT_WIDTH-1:0];

`ifdef KIM_IDEX_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  // Saturating event counters; they stop at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (stall_in && (r_hold_cnt != 32'hFFFF_FFFF)) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_out = r_bubble_cnt;
  assign hold_cnt_out   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_kim_id_ex_reg_p.sv
// Scoreboard bench for kim_id_ex_reg_p: the stimulus process predicts each cycle's
// stall request and next EX contents; a monitor process pops and checks them.
module tb_kim_id_ex_reg_p;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
  } slot_t;

  typedef struct packed {
    logic  chk_stall;
    logic  exp_stall;
    slot_t exp_state;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in;
  logic        id_valid_in;
  logic [1:0]  id_alu_op_in;
  logic        id_alu_src_in, id_reg_dst_in, id_branch_in, id_mem_read_in;
  logic        id_mem_write_in, id_reg_write_in, id_mem_to_reg_in;
  logic [31:0] id_rs_data_in, id_rt_data_in, id_imm_in, id_pc_plus4_in;
  logic [4:0]  id_rs_addr_in, id_rt_addr_in, id_rd_addr_in;

  logic        ex_valid_out;
  logic [1:0]  ex_alu_op_out;
  logic        ex_alu_src_out, ex_reg_dst_out, ex_branch_out, ex_mem_read_out;
  logic        ex_mem_write_out, ex_reg_write_out, ex_mem_to_reg_out;
  logic [31:0] ex_rs_data_out, ex_rt_data_out, ex_imm_out, ex_pc_plus4_out;
  logic [4:0]  ex_rs_addr_out, ex_rt_addr_out, ex_rd_addr_out;
  logic [5:0]  ex_funct_out;
  logic        load_use_stall_out;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t  sb_q[$];
  slot_t model;
  logic  model_known = 1'b0;

  always #5 clk = ~clk;

  kim_id_ex_reg_p dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid_in(id_valid_in), .id_alu_op_in(id_alu_op_in),
    .id_alu_src_in(id_alu_src_in), .id_reg_dst_in(id_reg_dst_in),
    .id_branch_in(id_branch_in), .id_mem_read_in(id_mem_read_in),
    .id_mem_write_in(id_mem_write_in), .id_reg_write_in(id_reg_write_in),
    .id_mem_to_reg_in(id_mem_to_reg_in),
    .id_rs_data_in(id_rs_data_in), .id_rt_data_in(id_rt_data_in),
    .id_imm_in(id_imm_in), .id_pc_plus4_in(id_pc_plus4_in),
    .id_rs_addr_in(id_rs_addr_in), .id_rt_addr_in(id_rt_addr_in),
    .id_rd_addr_in(id_rd_addr_in),
    .ex_valid_out(ex_valid_out), .ex_alu_op_out(ex_alu_op_out),
    .ex_alu_src_out(ex_alu_src_out), .ex_reg_dst_out(ex_reg_dst_out),
    .ex_branch_out(ex_branch_out), .ex_mem_read_out(ex_mem_read_out),
    .ex_mem_write_out(ex_mem_write_out), .ex_reg_write_out(ex_reg_write_out),
    .ex_mem_to_reg_out(ex_mem_to_reg_out),
    .ex_rs_data_out(ex_rs_data_out), .ex_rt_data_out(ex_rt_data_out),
    .ex_imm_out(ex_imm_out), .ex_pc_plus4_out(ex_pc_plus4_out),
    .ex_rs_addr_out(ex_rs_addr_out), .ex_rt_addr_out(ex_rt_addr_out),
    .ex_rd_addr_out(ex_rd_addr_out), .ex_funct_out(ex_funct_out),
    .load_use_stall_out(load_use_stall_out)
  );

  function automatic slot_t dut_state();
    slot_t s;
    s = '{valid: ex_valid_out, alu_op: ex_alu_op_out, alu_src: ex_alu_src_out,
          reg_dst: ex_reg_dst_out, branch: ex_branch_out, mem_read: ex_mem_read_out,
          mem_write: ex_mem_write_out, reg_write: ex_reg_write_out,
          mem_to_reg: ex_mem_to_reg_out, rs_data: ex_rs_data_out,
          rt_data: ex_rt_data_out, imm: ex_imm_out, pc4: ex_pc_plus4_out,
          rs_a: ex_rs_addr_out, rt_a: ex_rt_addr_out, rd_a: ex_rd_addr_out};
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.valid      = ($urandom_range(3) != 0);
    s.alu_op     = 2'($urandom_range(2));
    s.alu_src    = 1'($urandom);
    s.reg_dst    = 1'($urandom);
    s.branch     = 1'($urandom);
    s.mem_read   = ($urandom_range(2) == 0);
    s.mem_write  = 1'($urandom);
    s.reg_write  = 1'($urandom);
    s.mem_to_reg = 1'($urandom);
    s.rs_data    = $urandom;
    s.rt_data    = $urandom;
    s.imm        = $urandom;
    s.pc4        = $urandom;
    // Small register range makes address collisions (and so hazards) frequent.
    s.rs_a       = ($urandom_range(7) == 0) ? 5'($urandom) : 5'($urandom_range(3));
    s.rt_a       = ($urandom_range(7) == 0) ? 5'($urandom) : 5'($urandom_range(3));
    s.rd_a       = 5'($urandom);
    return s;
  endfunction

  // Decode-slot instruction builder for the directed part.
  function automatic slot_t instr(input logic [1:0] op, input logic mr, input logic rw,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] imm);
    slot_t s;
    s            = rnd_slot();
    s.valid      = 1'b1;
    s.alu_op     = op;
    s.mem_read   = mr;
    s.mem_write  = 1'b0;
    s.branch     = 1'b0;
    s.reg_write  = rw;
    s.mem_to_reg = mr;
    s.alu_src    = mr;
    s.reg_dst    = (op == 2'b10);
    s.rs_a       = rs;
    s.rt_a       = rt;
    s.rd_a       = rd;
    s.imm        = imm;
    return s;
  endfunction

  // One clock of stimulus: drive inputs, predict the stall request and next EX slot.
  task automatic step(input logic r, input logic fl, input logic st, input slot_t in);
    logic  dep, hz;
    slot_t nxt;
    rec_t  rec;
    @(negedge clk);
    rst = r; flush_in = fl; stall_in = st;
    id_valid_in = in.valid; id_alu_op_in = in.alu_op; id_alu_src_in = in.alu_src;
    id_reg_dst_in = in.reg_dst; id_branch_in = in.branch; id_mem_read_in = in.mem_read;
    id_mem_write_in = in.mem_write; id_reg_write_in = in.reg_write;
    id_mem_to_reg_in = in.mem_to_reg; id_rs_data_in = in.rs_data;
    id_rt_data_in = in.rt_data; id_imm_in = in.imm; id_pc_plus4_in = in.pc4;
    id_rs_addr_in = in.rs_a; id_rt_addr_in = in.rt_a; id_rd_addr_in = in.rd_a;

    // The instruction in ID needs the value a load in EX has not fetched yet.
    dep = (model.rt_a == in.rs_a) || (model.rt_a == in.rt_a);
    hz  = model_known && model.valid && model.mem_read && (model.rt_a != 5'd0) && in.valid && dep;

    if (r) begin
      nxt = '0;
    end else if (fl || (!st && hz)) begin
      nxt           = in;
      nxt.valid     = 1'b0;
      nxt.reg_write = 1'b0;
      nxt.mem_read  = 1'b0;
      nxt.mem_write = 1'b0;
      nxt.branch    = 1'b0;
      nxt.alu_op    = 2'b00;
    end else if (st) begin
      nxt = model;
    end else begin
      nxt = in;
    end

    rec.chk_stall = model_known;
    rec.exp_stall = hz && !fl;
    rec.exp_state = nxt;
    sb_q.push_back(rec);
    model = nxt;
    if (r) model_known = 1'b1;
  endtask

  // Monitor: stall request checked just before the edge, EX contents just after it.
  initial begin
    rec_t  rec;
    slot_t got;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        rec = sb_q.pop_front();
        if (rec.chk_stall) begin
          n_cmp++;
          if (load_use_stall_out !== rec.exp_stall) begin
            n_bad++;
            $display("FAIL load_use_stall t=%0t got=%b exp=%b", $time, load_use_stall_out, rec.exp_stall);
          end
        end
        @(posedge clk);
        #1;
        got = dut_state();
        n_cmp++;
        if (got !== rec.exp_state) begin
          n_bad++;
          $display("FAIL ex_state t=%0t got=%h exp=%h", $time, got, rec.exp_state);
        end else begin
          $display("txn t=%0t valid=%b alu_op=%b mr=%b rw=%b rt=%0d stall=%b",
                   $time, got.valid, got.alu_op, got.mem_read, got.reg_write, got.rt_a,
                   rec.exp_stall);
        end
        n_cmp++;
        if (ex_funct_out !== rec.exp_state.imm[5:0]) begin
          n_bad++;
          $display("FAIL ex_funct t=%0t got=%b exp=%b", $time, ex_funct_out, rec.exp_state.imm[5:0]);
        end
      end
    end
  end

  initial begin
    slot_t lw5, lw0, sub_dep, add_i, nop_i;
    model = '0;
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;

    // Reset with random inputs, two cycles.
    step(1'b1, 1'($urandom), 1'($urandom), rnd_slot());
    step(1'b1, 1'($urandom), 1'($urandom), rnd_slot());

    add_i   = instr(2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0000_0020);
    lw5     = instr(2'b00, 1'b1, 1'b1, 5'd1, 5'd5, 5'd0, 32'h0000_0010);
    lw0     = instr(2'b00, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 32'h0000_0004);
    sub_dep = instr(2'b10, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 32'h0000_0022);
    nop_i   = instr(2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

    // Plain R-type load, then a load-use pair: stall, bubble, retry.
    step(1'b0, 1'b0, 1'b0, add_i);
    step(1'b0, 1'b0, 1'b0, lw5);
    step(1'b0, 1'b0, 1'b0, sub_dep);
    step(1'b0, 1'b0, 1'b0, sub_dep);
    // Load into $0 never stalls.
    step(1'b0, 1'b0, 1'b0, lw0);
    sub_dep.rs_a = 5'd0;
    step(1'b0, 1'b0, 1'b0, sub_dep);
    sub_dep.rs_a = 5'd5;
    // Flush and stall together with a live hazard: bubble, no stall request.
    step(1'b0, 1'b0, 1'b0, lw5);
    step(1'b0, 1'b1, 1'b1, sub_dep);
    // Three-cycle hold with changing ID contents, including a hazard while held.
    step(1'b0, 1'b0, 1'b0, lw5);
    step(1'b0, 1'b0, 1'b1, rnd_slot());
    step(1'b0, 1'b0, 1'b1, sub_dep);
    step(1'b0, 1'b0, 1'b1, rnd_slot());
    step(1'b0, 1'b0, 1'b0, sub_dep);
    step(1'b0, 1'b0, 1'b0, nop_i);
    // Reset in the middle of a hazard.
    step(1'b0, 1'b0, 1'b0, lw5);
    step(1'b1, 1'b0, 1'b0, sub_dep);
    step(1'b0, 1'b0, 1'b0, sub_dep);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
           rnd_slot());
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kim_id_ex_reg_p.md
# kim_id_ex_reg_p

ID/EX pipeline register of the 32-bit pipelined MIPS core, between decode and execute. It captures decoded control, operands, immediate and register addresses each cycle and presents them to EX, including the alu_op/funct pair consumed by the ALU control decoder. It also contains load-use hazard detection, and supports hold (stall), branch flush and bubble insertion.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- REG_ADDR_WIDTH, 5, register-file address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- stall_in  in  1  freeze request from downstream (memory wait); hold all contents
- flush_in  in  1  branch-taken flush; load bubble
- id_valid_in  in  1  decode slot holds a real instruction
- id_alu_op_in  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type
- id_alu_src_in, id_reg_dst_in, id_branch_in, id_mem_read_in, id_mem_write_in, id_reg_write_in, id_mem_to_reg_in  in  1 each  decoded control
- id_rs_data_in, id_rt_data_in, id_imm_in, id_pc_plus4_in  in  DATA_WIDTH each  operands, sign-extended immediate, PC+4
- id_rs_addr_in, id_rt_addr_in, id_rd_addr_in  in  REG_ADDR_WIDTH each  register addresses
- ex_* outputs  out  same widths as the id_* inputs above  registered copies
- ex_valid_out  out  1  EX slot holds a real instruction
- ex_funct_out  out  6  registered id_imm_in[5:0], feeds ALU control
- load_use_stall_out  out  1  combinational; PC and IF/ID must hold this cycle

## Operation
- Per-edge priority: rst > flush_in > stall_in > load-use hazard > normal load.
- rst: every ex_* output, ex_funct_out and ex_valid_out = 0. The alu_op 00 after reset decodes as add.
- Bubble (flush_in, or a hazard while not stalled):
  - ex_valid_out, ex_reg_write_out, ex_mem_read_out, ex_mem_write_out and ex_branch_out = 0.
  - ex_alu_op_out = 00.
  - Data, address and remaining control fields load from the inputs (don't-care downstream).
- Hold (stall_in): all registers keep their values. Hazard is still evaluated, but no bubble is loaded.
- Normal: every field loads from id_*. ex_valid_out = id_valid_in.
- Hazard = all of the following: ex_valid_out, ex_mem_read_out, ex_rt_addr_out != 0, id_valid_in, and (ex_rt_addr_out == id_rs_addr_in or ex_rt_addr_out == id_rt_addr_in).
- load_use_stall_out = hazard & ~flush_in. A flush kills the dependent instruction, so no stall is requested.
- After one bubble, ex_mem_read_out = 0. A hazard therefore lasts exactly one cycle per load.

## Timing
- Latency: one clock from id_* to ex_*.
- load_use_stall_out is purely combinational from current ex_* state and id_* inputs, valid in the same cycle.
- flush_in and stall_in asserted together: flush wins, and a bubble is loaded.
- rst asserted mid-stall or mid-hazard: the next edge clears all state. load_use_stall_out falls once ex_valid_out = 0.
- No handshake backpressure beyond stall_in. The block never drops an instruction unless it is flushed.

## Configuration
- KIM_IDEX_PERF_EN defined:
  - Adds outputs bubble_cnt_out[31:0] and hold_cnt_out[31:0].
  - bubble_cnt_out increments on every bubble edge (flush or hazard). hold_cnt_out increments on every stall_in edge.
  - Both saturate at 32'hFFFF_FFFF, and rst clears them.
- KIM_IDEX_PERF_EN undefined: the ports and counters are absent, and the datapath is identical.

## Structure
- Shared package holds:
  - ALU_OP_ADD = 2'b00, ALU_OP_SUB = 2'b01, ALU_OP_RTYPE = 2'b10
  - FUNCT_WIDTH = 6
  - a packed control-bundle typedef covering alu_op, alu_src, reg_dst, branch, mem_read, mem_write, reg_write and mem_to_reg
- One sub-module: kim_load_use_detect_p. It is purely combinational, with inputs ex_valid/ex_mem_read/ex_rt_addr/id_valid/id_rs_addr/id_rt_addr and output hazard.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, ex_alu_op_out = 00, load_use_stall_out = 0.
- Normal load: add $3,$1,$2 (id_imm_in[5:0] = 6'b100000, alu_op 10, reg_write 1) -> next cycle ex_funct_out = 100000, ex_alu_op_out = 10, ex_valid_out = 1.
- Load-use: lw $5 in EX (mem_read 1, rt 5), then sub $6,$5,$7 in ID:
  - load_use_stall_out = 1 in that cycle.
  - Next edge loads a bubble (ex_reg_write_out = 0, ex_valid_out = 0), and load_use_stall_out returns to 0.
  - A lw into $0 gives no stall.
- Flush and stall same edge: flush_in = 1, stall_in = 1 -> bubble loaded, ex_valid_out = 0. A hazard present at the same time gives load_use_stall_out = 0.
- Stall hold: stall_in high 3 cycles while id_* changes -> ex_* constant; with KIM_IDEX_PERF_EN, hold_cnt_out = 3.
- Saturation, with KIM_IDEX_PERF_EN: force bubble_cnt_out near max, apply 2 flushes -> bubble_cnt_out = FFFF_FFFF.
